// File: rtl/sram_1rw1r_sync_clr.sv
// Behavioural 1RW+1R single-clock SRAM with a post-reset clear sequencer, byte-lane writes,
// read-valid strobes and deterministic same-address write/read forwarding on port 1.
module sram_1rw1r_sync_clr #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter bit          WRITE_FWD      = 1'b1,
  localparam int unsigned NUM_WMASKS    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  init_busy,
  output logic                  collision
);

  localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] merged;
  logic                  run, wr0, rd0, rd1, coll;

  assign run       = (state == ST_RUN);
  assign wr0       = run && !csb0 && !web0;
  assign rd0       = run && !csb0 && web0;
  assign rd1       = run && !csb1;
  assign coll      = wr0 && rd1 && (addr0 == addr1);
  assign init_busy = (state == ST_CLEAR);

  // Word as it will look after this cycle's port 0 write; also the forwarded value.
  always_comb begin
    merged = mem[addr0];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0[i]) merged[8*i +: 8] = din0[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      if (&clr_cnt) state <= ST_RUN;
      else          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end
  end

  // Array has no reset of its own; contents survive reset when the clear is disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) mem[clr_cnt] <= '0;
      else if (wr0)          mem[addr0]   <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout0       <= '0;
      dout1       <= '0;
      dout0_valid <= 1'b0;
      dout1_valid <= 1'b0;
      collision   <= 1'b0;
    end else begin
      dout0_valid <= rd0;
      dout1_valid <= rd1;
      collision   <= coll;
      if (rd0) dout0 <= mem[addr0];
      if (rd1) dout1 <= (WRITE_FWD && coll) ? merged : mem[addr1];
    end
  end

endmodule

// File: tb/tb_sram_1rw1r_sync_clr.sv
// Directed bench: clear sequencing, byte masks, collision forwarding (both settings),
// streaming reads and a 64-bit/no-clear instance.
module tb_sram_1rw1r_sync_clr;

  logic        clk = 1'b0;
  logic        reset;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;
  logic [31:0] a_d0, a_d1, b_d0, b_d1;
  logic        a_v0, a_v1, a_busy, a_col, b_v0, b_v1, b_busy, b_col;

  logic        c_csb0, c_web0, c_csb1;
  logic [7:0]  c_wmask0;
  logic [3:0]  c_addr0, c_addr1;
  logic [63:0] c_din0, c_d0, c_d1;
  logic        c_v0, c_v1, c_busy, c_col;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sram_1rw1r_sync_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CLEAR_ON_RESET(1'b1), .WRITE_FWD(1'b1)) dut_a (
    .clk(clk), .reset(reset), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(a_d0), .dout0_valid(a_v0), .csb1(csb1), .addr1(addr1),
    .dout1(a_d1), .dout1_valid(a_v1), .init_busy(a_busy), .collision(a_col));

  sram_1rw1r_sync_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CLEAR_ON_RESET(1'b1), .WRITE_FWD(1'b0)) dut_b (
    .clk(clk), .reset(reset), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(b_d0), .dout0_valid(b_v0), .csb1(csb1), .addr1(addr1),
    .dout1(b_d1), .dout1_valid(b_v1), .init_busy(b_busy), .collision(b_col));

  sram_1rw1r_sync_clr #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b0), .WRITE_FWD(1'b1)) dut_c (
    .clk(clk), .reset(reset), .csb0(c_csb0), .web0(c_web0), .wmask0(c_wmask0), .addr0(c_addr0),
    .din0(c_din0), .dout0(c_d0), .dout0_valid(c_v0), .csb1(c_csb1), .addr1(c_addr1),
    .dout1(c_d1), .dout1_valid(c_v1), .init_busy(c_busy), .collision(c_col));

  typedef struct {
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] e_d0;
    logic        e_v0;
    logic [31:0] e_d1;
    logic        e_v1, e_col;
    logic [31:0] e_d1b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic cs0, input logic we0, input logic [3:0] m,
                              input logic [7:0] a0, input logic [31:0] d, input logic cs1,
                              input logic [7:0] a1, input logic [31:0] ed0, input logic ev0,
                              input logic [31:0] ed1, input logic ev1, input logic ecol,
                              input logic [31:0] ed1b);
    vec_t v;
    v.csb0 = cs0; v.web0 = we0; v.wmask0 = m; v.addr0 = a0; v.din0 = d;
    v.csb1 = cs1; v.addr1 = a1; v.e_d0 = ed0; v.e_v0 = ev0; v.e_d1 = ed1;
    v.e_v1 = ev1; v.e_col = ecol; v.e_d1b = ed1b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0; csb1 = 1'b1; addr1 = '0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle();
    c_csb0 = 1'b1; c_web0 = 1'b1; c_wmask0 = '0; c_addr0 = '0; c_din0 = '0;
    c_csb1 = 1'b1; c_addr1 = '0;

    // Reset held two cycles, then a full clear.
    tick(); tick();
    chk("rst_a_d0", a_d0, 0);       chk("rst_a_d1", a_d1, 0);
    chk("rst_a_v0", a_v0, 0);       chk("rst_a_v1", a_v1, 0);
    chk("rst_a_col", a_col, 0);     chk("rst_a_busy", a_busy, 1);
    chk("rst_c_busy", c_busy, 0);   chk("rst_c_d0", c_d0, 0);
    reset = 1'b0;
    n = 0;
    while (a_busy && n < 1000) begin tick(); n++; end
    chk("clear_len", n, 256);
    chk("clear_len_b", b_busy, 0);
    csb1 = 1'b0; addr1 = 8'hFF;
    tick();
    chk("clr_ff_d1", a_d1, 0);      chk("clr_ff_v1", a_v1, 1);
    idle();

    // Reset reasserted 100 cycles into a clear restarts it from zero.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_busy", a_busy, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    n = 0;
    while (a_busy && n < 1000) begin
      if (n == 50) begin
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'h30; din0 = 32'hDEADBEEF;
        csb1 = 1'b0; addr1 = 8'h30;
      end
      tick(); n++;
      if (n == 51) begin
        chk("clr_v0", a_v0, 0); chk("clr_v1", a_v1, 0); chk("clr_col", a_col, 0);
        idle();
      end
    end
    chk("reclear_len", n, 256);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h30; csb1 = 1'b0; addr1 = 8'hFF;
    tick();
    chk("clr_wr_absent", a_d0, 0);  chk("clr_rd_v0", a_v0, 1);
    chk("clr_ff2_d1", a_d1, 0);     chk("clr_ff2_v1", a_v1, 1);

    // Main vector table; expected columns are the outputs one edge after the inputs.
    tbl.push_back(mk(0,0,4'hF,8'h10,32'hAABBCCDD,1,0, 32'h0,0, 32'h0,0,0, 32'h0));
    tbl.push_back(mk(0,0,4'h5,8'h10,32'h11223344,1,0, 32'h0,0, 32'h0,0,0, 32'h0));
    tbl.push_back(mk(0,1,4'h0,8'h10,32'h0,       1,0, 32'hAA22CC44,1, 32'h0,0,0, 32'h0));
    tbl.push_back(mk(1,1,4'h0,8'h00,32'h0,       1,0, 32'hAA22CC44,0, 32'h0,0,0, 32'h0));
    tbl.push_back(mk(0,0,4'hF,8'h20,32'h12345678,1,0, 32'hAA22CC44,0, 32'h0,0,0, 32'h0));
    tbl.push_back(mk(0,0,4'hC,8'h20,32'hFFFF0000,0,8'h20, 32'hAA22CC44,0, 32'hFFFF5678,1,1, 32'h12345678));
    tbl.push_back(mk(0,1,4'h0,8'h20,32'h0,       0,8'h20, 32'hFFFF5678,1, 32'hFFFF5678,1,0, 32'hFFFF5678));
    tbl.push_back(mk(0,0,4'h0,8'h21,32'hFFFFFFFF,1,0, 32'hFFFF5678,0, 32'hFFFF5678,0,0, 32'hFFFF5678));
    tbl.push_back(mk(1,1,4'h0,8'h00,32'h0,       0,8'h21, 32'hFFFF5678,0, 32'h0,1,0, 32'h0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,0,4'hF,8'(i),32'(i),    1,0, 32'hFFFF5678,0, 32'h0,0,0, 32'h0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1,1,4'h0,8'h00,32'h0,     0,8'(i), 32'hFFFF5678,0, 32'(i),1,0, 32'(i)));
    tbl.push_back(mk(1,1,4'h0,8'h00,32'h0,       1,0, 32'hFFFF5678,0, 32'h7,0,0, 32'h7));
    tbl.push_back(mk(0,0,4'hF,8'h50,32'hCAFEBABE,0,8'h07, 32'hFFFF5678,0, 32'h7,1,0, 32'h7));
    tbl.push_back(mk(0,1,4'h0,8'h50,32'h0,       1,0, 32'hCAFEBABE,1, 32'h7,0,0, 32'h7));

    foreach (tbl[i]) begin
      csb0 = tbl[i].csb0; web0 = tbl[i].web0; wmask0 = tbl[i].wmask0; addr0 = tbl[i].addr0;
      din0 = tbl[i].din0; csb1 = tbl[i].csb1; addr1 = tbl[i].addr1;
      tick();
      chk($sformatf("v%0d_d0", i), a_d0, tbl[i].e_d0);
      chk($sformatf("v%0d_v0", i), a_v0, tbl[i].e_v0);
      chk($sformatf("v%0d_d1", i), a_d1, tbl[i].e_d1);
      chk($sformatf("v%0d_v1", i), a_v1, tbl[i].e_v1);
      chk($sformatf("v%0d_col", i), a_col, tbl[i].e_col);
      chk($sformatf("v%0d_d1_nofwd", i), b_d1, tbl[i].e_d1b);
      chk($sformatf("v%0d_col_nofwd", i), b_col, tbl[i].e_col);
    end

    // Reset during RUN with reads requested: reads discarded.
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h50; csb1 = 1'b0; addr1 = 8'h50;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("runrst_d0", a_d0, 0);      chk("runrst_v0", a_v0, 0);
    chk("runrst_d1", a_d1, 0);      chk("runrst_v1", a_v1, 0);
    chk("runrst_busy", a_busy, 1);

    // 64-bit, 16-deep, no clear: lane mask 0x81 touches only bytes 7 and 0.
    chk("c_busy", c_busy, 0);
    c_csb0 = 1'b0; c_web0 = 1'b0; c_addr0 = 4'h3; c_wmask0 = 8'hFF; c_din0 = 64'h0123456789ABCDEF;
    tick();
    c_wmask0 = 8'h81; c_din0 = 64'hFFEEDDCCBBAA9988;
    tick();
    chk("c_wr_v0", c_v0, 0);
    c_web0 = 1'b1;
    tick();
    chk("c_rd_d0", c_d0, 64'hFF23456789ABCD88);
    chk("c_rd_v0", c_v0, 1);
    c_csb0 = 1'b1;
    tick();
    chk("c_hold_d0", c_d0, 64'hFF23456789ABCD88);
    chk("c_hold_v0", c_v0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
